// File: rtl/nla_fp_pkg.sv
// Shared IEEE-754 binary32 field widths, operand classes and the unpacked-operand record.
// Used by fp32_unpack, fp32_to_fixed and future FP blocks.
package nla_fp_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_BIAS  = 127;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_t;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W:0]   mant;   // hidden one prepended
        fp_class_t             cls;
    } fp_unpacked_t;

    // Denormals fall into FP_ZERO: they are flushed rather than converted.
    function automatic fp_class_t fp_classify(input logic [FP32_EXP_W-1:0] e,
                                              input logic [FP32_MAN_W-1:0] m);
        if (e == '0) return FP_ZERO;
        if (e == '1) return (m == '0) ? FP_INF : FP_NAN;
        return FP_NORM;
    endfunction

endpackage

// File: rtl/fp32_to_fixed_if.sv
// Valid/ready stream bundle for fp32_to_fixed: FP32 operand in, fixed-point result and flags out.
// The slave modport is the converter side, the master modport the producer/consumer side.
interface fp32_to_fixed_if #(
    parameter int OUT_W = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      in_data_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [OUT_W-1:0] out_data_o;
    logic             out_ovf_o;
    logic             out_nan_o;

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_ovf_o, out_nan_o
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_ovf_o, out_nan_o
    );
endinterface

// File: rtl/fp32_unpack.sv
// Combinational binary32 unpack/classify stage: splits sign/exponent, restores the hidden one
// and tags the operand as ZERO (incl. flushed denormals), NORM, INF or NAN.
module fp32_unpack
    import nla_fp_pkg::*;
(
    input  logic [31:0]  fp_i,
    output fp_unpacked_t op_o
);

    always_comb begin
        op_o.sign = fp_i[31];
        op_o.exp  = fp_i[30:23];
        op_o.mant = {1'b1, fp_i[22:0]};
        op_o.cls  = fp_classify(fp_i[30:23], fp_i[22:0]);
    end

endmodule

// File: rtl/fp32_to_fixed.sv
// Three-stage binary32 -> signed fixed-point (FRAC_W fractional bits) converter, falling-edge clocked.
// Define FP2FIX_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp32_to_fixed
    import nla_fp_pkg::*;
#(
    parameter int OUT_W  = 32,
    parameter int FRAC_W = 16
) (
    input  logic           clkn_i,
    input  logic           rst_i,
    fp32_to_fixed_if.slave bus
);

    localparam int WIDE_W = OUT_W + FP32_MAN_W + 1;
    localparam int HI_W   = WIDE_W - OUT_W + 1;
    localparam logic [9:0]       K_OFFSET = 10'(FP32_BIAS + FP32_MAN_W);
    localparam logic [OUT_W:0]   LIM_POS  = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W:0]   LIM_NEG  = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] SAT_POS  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG  = {1'b1, {(OUT_W-1){1'b0}}};

    logic         en;
    fp_unpacked_t unp;

    logic         s1_valid_d, s1_valid_q;
    fp_unpacked_t s1_op_d, s1_op_q;

    logic             s2_valid_d, s2_valid_q;
    logic             s2_sign_d, s2_sign_q;
    fp_class_t        s2_cls_d, s2_cls_q;
    logic [OUT_W-1:0] s2_mag_d, s2_mag_q;
    logic             s2_ovf_d, s2_ovf_q;
`ifdef FP2FIX_RNE_EN
    logic             s2_rnd_d, s2_rnd_q;
    logic             s2_stk_d, s2_stk_q;
    logic             al_rnd, al_stk;
    logic [47:0]      frac_ext;
`endif

    logic             out_valid_d, out_valid_q;
    logic [OUT_W-1:0] out_data_d, out_data_q;
    logic             out_ovf_d, out_ovf_q;
    logic             out_nan_d, out_nan_q;

    logic signed [9:0] k;
    logic [9:0]        k_neg;
    logic [WIDE_W-1:0] wide;
    logic [HI_W-1:0]   hi;
    logic [OUT_W-1:0]  al_mag;
    logic              al_ovf;
    logic [OUT_W:0]    mag_rnd;
    logic              mag_ovf;

    fp32_unpack u_unpack (
        .fp_i (bus.in_data_i),
        .op_o (unp)
    );

    // A stalled output freezes the whole pipeline; bubbles are carried, never squeezed out.
    assign en              = ~out_valid_q | bus.out_ready_i;
    assign bus.in_ready_o  = en;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_ovf_o   = out_ovf_q;
    assign bus.out_nan_o   = out_nan_q;

    always_comb begin
        s1_valid_d = en ? bus.in_valid_i : s1_valid_q;
        s1_op_d    = (en && bus.in_valid_i) ? unp : s1_op_q;
    end

    // S2 align: k is the left-shift that places the mantissa LSB at the fixed-point weight.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        k      = {2'b00, s1_op_q.exp} + 10'(FRAC_W) - K_OFFSET;
        k_neg  = -k;
        wide   = '0;
        hi     = '0;
        al_mag = '0;
        al_ovf = 1'b0;
`ifdef FP2FIX_RNE_EN
        frac_ext = '0;
        al_rnd   = 1'b0;
        al_stk   = 1'b0;
`endif
        if (s1_op_q.cls == FP_NORM) begin
            if (!k[9]) begin
                if (k[8:0] > 9'(OUT_W)) begin
                    al_ovf = 1'b1;
                end else begin
                    wide   = WIDE_W'(s1_op_q.mant) << k[8:0];
                    hi     = wide[WIDE_W-1:OUT_W-1];
                    al_mag = wide[OUT_W-1:0];
                    // Only exactly -2^(OUT_W-1) may occupy the sign-bit weight.
                    al_ovf = (hi != '0) &&
                             !(s1_op_q.sign && hi == HI_W'(1) && wide[OUT_W-2:0] == '0);
                end
            end else begin
`ifdef FP2FIX_RNE_EN
                if (k_neg >= 10'd25) begin
                    al_stk = 1'b1;
                end else begin
                    frac_ext = {s1_op_q.mant, 24'b0} >> k_neg;
                    al_mag   = OUT_W'(frac_ext[47:24]);
                    al_rnd   = frac_ext[23];
                    al_stk   = |frac_ext[22:0];
                end
`else
                al_mag = OUT_W'(s1_op_q.mant >> k_neg);
`endif
            end
        end
    end

    always_comb begin
        s2_valid_d = en ? s1_valid_q : s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_cls_d   = s2_cls_q;
        s2_mag_d   = s2_mag_q;
        s2_ovf_d   = s2_ovf_q;
`ifdef FP2FIX_RNE_EN
        s2_rnd_d   = s2_rnd_q;
        s2_stk_d   = s2_stk_q;
`endif
        if (en && s1_valid_q) begin
            s2_sign_d = s1_op_q.sign;
            s2_cls_d  = s1_op_q.cls;
            s2_mag_d  = al_mag;
            s2_ovf_d  = al_ovf;
`ifdef FP2FIX_RNE_EN
            s2_rnd_d  = al_rnd;
            s2_stk_d  = al_stk;
`endif
        end
    end

    // S3 round, negate and saturate; the rounding increment can itself push past the limit.
    always_comb begin
        mag_rnd = {1'b0, s2_mag_q};
`ifdef FP2FIX_RNE_EN
        mag_rnd = mag_rnd + {{OUT_W{1'b0}}, s2_rnd_q & (s2_stk_q | s2_mag_q[0])};
`endif
        mag_ovf = s2_ovf_q || (mag_rnd > (s2_sign_q ? LIM_NEG : LIM_POS));

        out_valid_d = en ? s2_valid_q : out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_nan_d   = out_nan_q;
        if (en && s2_valid_q) begin
            out_data_d = '0;
            out_ovf_d  = 1'b0;
            out_nan_d  = 1'b0;
            case (s2_cls_q)
                FP_NAN: out_nan_d = 1'b1;
                FP_INF: begin
                    out_data_d = s2_sign_q ? SAT_NEG : SAT_POS;
                    out_ovf_d  = 1'b1;
                end
                FP_NORM: begin
                    if (mag_ovf) begin
                        out_data_d = s2_sign_q ? SAT_NEG : SAT_POS;
                        out_ovf_d  = 1'b1;
                    end else begin
                        out_data_d = s2_sign_q ? -mag_rnd[OUT_W-1:0] : mag_rnd[OUT_W-1:0];
                    end
                end
                default: out_data_d = '0;
            endcase
        end
    end

    always_ff @(negedge clkn_i) begin
        // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_nan_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_nan_q   <= out_nan_d;
        end
    end

    always_ff @(negedge clkn_i) begin
        // NOTE: datapath registers carry no reset; the stage valids qualify their contents.
        s1_op_q   <= s1_op_d;
        s2_sign_q <= s2_sign_d;
        s2_cls_q  <= s2_cls_d;
        s2_mag_q  <= s2_mag_d;
        s2_ovf_q  <= s2_ovf_d;
`ifdef FP2FIX_RNE_EN
        s2_rnd_q  <= s2_rnd_d;
        s2_stk_q  <= s2_stk_d;
`endif
    end

endmodule

// File: tb/tb_fp32_to_fixed.sv
// Self-checking bench for fp32_to_fixed: directed vector table, backpressure and mid-stream reset
// sequences, then a random stream against a real-arithmetic reference model.
module tb_fp32_to_fixed;

    localparam int OUT_W  = 32;
    localparam int FRAC_W = 16;
    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;
`ifdef FP2FIX_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] din;
        logic [31:0] dout;
        logic        ovf;
        logic        nan;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic        ovf;
        logic        nan;
    } res_t;

    logic clkn = 1'b0;
    logic rst  = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    fp32_to_fixed_if #(.OUT_W(OUT_W)) bus ();

    fp32_to_fixed #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (
        .clkn_i (clkn),
        .rst_i  (rst),
        .bus    (bus)
    );

    always #5 clkn = ~clkn;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact real value of the operand scaled by 2^FRAC_W, then rounded and clamped.
    function automatic res_t model(input logic [31:0] x);
        res_t   r;
        int     e;
        int     sh;
        real    mag;
        real    fl;
        longint iv;
        longint lim;
        logic   s;
`ifdef FP2FIX_RNE_EN
        real    fr;
`endif
        s = x[31];
        e = int'(x[30:23]);
        r = '{d: 32'h0, ovf: 1'b0, nan: 1'b0};
        if (e == 255) begin
            if (x[22:0] != 23'h0) r.nan = 1'b1;
            else begin
                r.ovf = 1'b1;
                r.d   = s ? SAT_NEG : SAT_POS;
            end
            return r;
        end
        if (e == 0) return r;
        sh  = e - 150 + FRAC_W;
        mag = (8388608.0 + real'(x[22:0])) * (2.0 ** sh);
        if (mag >= 2.0 ** (OUT_W + 1)) begin
            r.ovf = 1'b1;
            r.d   = s ? SAT_NEG : SAT_POS;
            return r;
        end
        fl = $floor(mag);
        iv = longint'(fl);
`ifdef FP2FIX_RNE_EN
        fr = mag - fl;
        if (fr > 0.5 || (fr == 0.5 && iv[0])) iv++;
`endif
        lim = s ? (longint'(1) <<< (OUT_W - 1)) : (longint'(1) <<< (OUT_W - 1)) - 1;
        if (iv > lim) begin
            r.ovf = 1'b1;
            r.d   = s ? SAT_NEG : SAT_POS;
        end else begin
            r.d = 32'(s ? -iv : iv);
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] specials [6];
        specials = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h0000_0001,
                     32'hC700_0000, 32'h4700_0000};
        case ($urandom_range(0, 9))
            0:       return $urandom();
            1:       return specials[$urandom_range(0, 5)];
            default: return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 160)),
                             23'($urandom())};
        endcase
    endfunction

    // One isolated transfer with out_ready held high; checks latency and all result fields.
    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        @(posedge clkn);
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = v.din;
        bus.out_ready_i = 1'b1;
        @(posedge clkn);
        bus.in_valid_i = 1'b0;
        lat = 1;
        #1;
        while (!bus.out_valid_o && lat < 10) begin
            @(posedge clkn);
            #1;
            lat++;
        end
        check($sformatf("vec%0d latency", idx), 64'(lat), 64'd3);
        check($sformatf("vec%0d data", idx), 64'(bus.out_data_o), 64'(v.dout));
        check($sformatf("vec%0d ovf", idx), 64'(bus.out_ovf_o), 64'(v.ovf));
        check($sformatf("vec%0d nan", idx), 64'(bus.out_nan_o), 64'(v.nan));
    endtask

    vec_t        vecs [20];
    logic [31:0] bp_in  [4];
    logic [31:0] bp_exp [4];
    logic [31:0] bp_got [$];
    logic [31:0] in_q   [$];
    res_t        exp_q  [$];

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = 32'h0;
        bus.out_ready_i = 1'b1;

        vecs[0]  = '{32'h3F80_0000, 32'h0001_0000, 1'b0, 1'b0};
        vecs[1]  = '{32'hC020_0000, 32'hFFFD_8000, 1'b0, 1'b0};
        vecs[2]  = '{32'h37C0_0000, RNE ? 32'h2 : 32'h1, 1'b0, 1'b0};
        vecs[3]  = '{32'h3700_0000, 32'h0, 1'b0, 1'b0};
        vecs[4]  = '{32'h4700_0000, SAT_POS, 1'b1, 1'b0};
        vecs[5]  = '{32'hC700_0000, SAT_NEG, 1'b0, 1'b0};
        vecs[6]  = '{32'hFF80_0000, SAT_NEG, 1'b1, 1'b0};
        vecs[7]  = '{32'h7FC0_0000, 32'h0, 1'b0, 1'b1};
        vecs[8]  = '{32'h0000_0001, 32'h0, 1'b0, 1'b0};
        vecs[9]  = '{32'h7F80_0000, SAT_POS, 1'b1, 1'b0};
        vecs[10] = '{32'h8000_0000, 32'h0, 1'b0, 1'b0};
        vecs[11] = '{32'h3740_0000, RNE ? 32'h1 : 32'h0, 1'b0, 1'b0};
        vecs[12] = '{32'h3700_0001, RNE ? 32'h1 : 32'h0, 1'b0, 1'b0};
        vecs[13] = '{32'h36FF_FFFF, 32'h0, 1'b0, 1'b0};
        vecs[14] = '{32'h46FF_FFFE, 32'h7FFF_FF00, 1'b0, 1'b0};
        vecs[15] = '{32'hC700_0001, SAT_NEG, 1'b1, 1'b0};
        vecs[16] = '{32'h4F00_0000, SAT_POS, 1'b1, 1'b0};
        vecs[17] = '{32'h3F00_0000, 32'h0000_8000, 1'b0, 1'b0};
        vecs[18] = '{32'hB7C0_0000, RNE ? 32'hFFFF_FFFE : 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[19] = '{32'h3820_0000, 32'h2, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clkn);
        @(posedge clkn);
        #1;
        check("reset out_valid", 64'(bus.out_valid_o), 64'd0);
        check("reset out_data", 64'(bus.out_data_o), 64'd0);
        check("reset ovf", 64'(bus.out_ovf_o), 64'd0);
        check("reset nan", 64'(bus.out_nan_o), 64'd0);
        check("reset in_ready", 64'(bus.in_ready_o), 64'd1);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) run_vec(i, vecs[i]);

        // Backpressure: four back-to-back operands, out_ready dropped for 5 cycles at first output
        bp_in  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        bp_exp = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
        begin
            int sent;
            int stall;
            bit stall_done;
            sent       = 0;
            stall      = 0;
            stall_done = 1'b0;
            for (int c = 0; c < 40 && bp_got.size() < 4; c++) begin
                @(posedge clkn);
                if (bus.out_valid_o && !stall_done) begin
                    stall      = 5;
                    stall_done = 1'b1;
                end
                bus.out_ready_i = (stall == 0);
                bus.in_valid_i  = (sent < 4);
                if (sent < 4) bus.in_data_i = bp_in[sent];
                #1;
                if (stall > 0) begin
                    check("bp stall in_ready", 64'(bus.in_ready_o), 64'd0);
                    check("bp stall hold", 64'(bus.out_data_o), 64'h0001_0000);
                    stall--;
                end
                if (bus.out_valid_o && bus.out_ready_i) bp_got.push_back(bus.out_data_o);
                if (bus.in_valid_i && bus.in_ready_o) sent++;
            end
            bus.in_valid_i  = 1'b0;
            bus.out_ready_i = 1'b1;
            check("bp output count", 64'(bp_got.size()), 64'd4);
            for (int i = 0; i < 4 && i < bp_got.size(); i++)
                check($sformatf("bp out%0d", i), 64'(bp_got[i]), 64'(bp_exp[i]));
        end
        repeat (4) @(posedge clkn);

        // Reset with two operands in flight
        begin
            int stale;
            @(posedge clkn);
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = 32'h3F80_0000;
            #1;
            check("rst pre accept", 64'(bus.in_ready_o), 64'd1);
            @(posedge clkn);
            bus.in_data_i = 32'h4000_0000;
            @(posedge clkn);
            bus.in_valid_i = 1'b0;
            rst = 1'b1;
            @(posedge clkn);
            #1;
            check("rst out_valid", 64'(bus.out_valid_o), 64'd0);
            check("rst out_data", 64'(bus.out_data_o), 64'd0);
            rst   = 1'b0;
            stale = 0;
            for (int c = 0; c < 8; c++) begin
                @(posedge clkn);
                #1;
                if (bus.out_valid_o) stale++;
            end
            check("rst stale outputs", 64'(stale), 64'd0);
        end

        // Random stream with random backpressure
        begin
            int          n_in;
            int          n_out;
            int          cyc;
            bit          held;
            logic [34:0] held_val;
            res_t        e;
            n_in  = 0;
            n_out = 0;
            cyc   = 0;
            held  = 1'b0;
            held_val = '0;
            for (int i = 0; i < 10000; i++) in_q.push_back(rand_fp());
            while (n_out < 10000 && cyc < 80000) begin
                @(posedge clkn);
                bus.out_ready_i = ($urandom_range(0, 9) < 7);
                bus.in_valid_i  = (in_q.size() > 0) && ($urandom_range(0, 9) < 8);
                if (in_q.size() > 0) bus.in_data_i = in_q[0];
                #1;
                if (held)
                    check("rand hold", 64'({bus.out_valid_o, bus.out_nan_o, bus.out_ovf_o,
                                            bus.out_data_o}), 64'(held_val));
                held     = bus.out_valid_o && !bus.out_ready_i;
                held_val = {bus.out_valid_o, bus.out_nan_o, bus.out_ovf_o, bus.out_data_o};
                if (bus.out_valid_o && bus.out_ready_i) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        check("rand unexpected output", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("rand out%0d", n_out),
                              64'({bus.out_nan_o, bus.out_ovf_o, bus.out_data_o}),
                              64'({e.nan, e.ovf, e.d}));
                    end
                end
                if (bus.in_valid_i && bus.in_ready_o) begin
                    exp_q.push_back(model(in_q[0]));
                    void'(in_q.pop_front());
                    n_in++;
                end
                cyc++;
            end
            bus.in_valid_i = 1'b0;
            check("rand inputs accepted", 64'(n_in), 64'd10000);
            check("rand output count", 64'(n_out), 64'(n_in));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fp32_to_fixed.md
Name: fp32_to_fixed

Overview:
- Pipelined converter from IEEE-754 binary32 to signed two's-complement fixed point (Q format, FRAC_W fractional bits).
- It is the decode/unpack counterpart of the FP32 normalising adder datapath.
- It hands approximation-engine results to integer/fixed-point consumers such as LUT indexers and DMA writers.
- It uses a valid/ready stream on both sides with a fixed 3-stage pipeline.

Parameters:
- OUT_W, 32, width of the fixed-point result (range 26..48).
- FRAC_W, 16, number of fractional bits in the result (range 0..OUT_W-2).

Ports:
- clkn_i  input  1  clock; all registers update on the falling edge.
- rst_i  input  1  synchronous active-high reset, sampled on the falling edge of clkn_i.
- in_valid_i  input  1  in_data_i is valid.
- in_ready_o  output  1  block accepts in_data_i this edge.
- in_data_i  input  32  FP32 operand.
- out_valid_o  output  1  out_data_o and the flags are valid.
- out_ready_i  input  1  downstream accepts the output.
- out_data_o  output  OUT_W  signed fixed-point result.
- out_ovf_o  output  1  result saturated, or input was ±Inf.
- out_nan_o  output  1  input was NaN; out_data_o is 0.

Behaviour:
- Reset: out_valid_o=0, out_data_o=0, out_ovf_o=0, out_nan_o=0. All stage valids are cleared. Any in-flight data is discarded. Reset wins over every other event on the same edge.
- Pipeline enable: en = ~out_valid_o | out_ready_i; in_ready_o = en (combinational).
- When en=0, all stages hold. Outputs stay stable while out_valid_o=1 and out_ready_i=0.
- Bubbles do not collapse.
- A transfer occurs on the input when in_valid_i & in_ready_o, and on the output when out_valid_o & out_ready_i.
- Latency is 3 enabled edges from input transfer to out_valid_o.
- Throughput is 1 per cycle when out_ready_i is held high.
- S1 (unpack/classify):
  - sign s, exponent e, M = {1, mant} (24b).
  - Classes: ZERO (e=0, covers ±0 and denormals, which are flushed), NORM, INF (e=255, mant=0), NAN (e=255, mant≠0).
- S2 (align):
  - k = e - 150 + FRAC_W, signed 10-bit.
  - k≥0: mag = M << k in an (OUT_W+1)-bit field. Overflow if any bit would be lost or if mag ≥ 2^(OUT_W-1) (plus 1 allowed when s=1).
  - k<0: mag = M >> -k, capturing round bit R and sticky S.
  - -k ≥ 26 gives mag=0, R=0, S=1.
  - -k = 25 gives mag=0, R=0, S=1.
  - -k = 24 gives mag=0, R=1, S=|mant.
- S3 (round/sign/saturate):
  - Round to nearest even: increment when R & (S | mag[0]). The increment may itself cause overflow.
  - s=1: result = -mag.
  - Overflow saturates to 2^(OUT_W-1)-1 (s=0) or -2^(OUT_W-1) (s=1), with ovf=1.
  - Exactly -2^(OUT_W-1) is representable and is not an overflow.
  - INF: saturate by sign, ovf=1.
  - NAN: data=0, nan=1, ovf=0.
  - ZERO: data=0, no flags.
- Input data is ignored when in_valid_i=0. A stage valid propagates only with en.

Optional Feature:
- Macro: FP2FIX_RNE_EN.
- Defined: round-to-nearest-even in S3 as specified above.
- Undefined: truncation toward zero. R and S are ignored and no increment logic is synthesised.
- Saturation, flags and latency are identical in both builds.

Decomposition:
- Package nla_fp_pkg holds:
  - FP32_EXP_W=8, FP32_MAN_W=23, FP32_BIAS=127.
  - fp_class_t enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}.
  - A packed struct for the unpacked operand (sign, exp, 24b mantissa, class).
- Sub-module fp32_unpack: purely combinational S1 classifier. It is shared with future FP blocks.

Test Plan (OUT_W=32, FRAC_W=16, out_ready_i=1 unless stated):
- 0x3F800000 (1.0) → 0x00010000 three edges later, flags 0. 0xC0200000 (-2.5) → 0xFFFD8000.
- Rounding:
  - 0x37C00000 (1.5 LSB) → 0x00000002; 0x37000000 (0.5 LSB) → 0x00000000.
  - With FP2FIX_RNE_EN undefined, these give 0x00000001 and 0x00000000.
- Saturation and specials:
  - 0x47000000 (+32768.0) → 0x7FFFFFFF, ovf=1.
  - 0xC7000000 (-32768.0) → 0x80000000, ovf=0.
  - 0xFF800000 (-Inf) → 0x80000000, ovf=1.
  - 0x7FC00000 (NaN) → 0, nan=1.
  - 0x00000001 (denormal) → 0, no flags.
- Backpressure:
  - Stream 1.0, 2.0, 3.0, 4.0 back-to-back and drop out_ready_i for 5 cycles after the first output.
  - Required: in_ready_o=0 during the stall, out_data_o held at 0x00010000, no loss.
  - Outputs 0x00010000, 0x00020000, 0x00030000, 0x00040000 appear in order.
- Reset mid-stream: assert rst_i for one edge with 2 operands in flight → out_valid_o=0 on that edge, and no stale result appears after release.
- Continuous random stream of 10k operands with random out_ready_i → every result matches the reference model. Output count equals input count.
